io_hub: RTL and testbench

Memory-mapped peripheral hub for the tiny16 CPU bus: decodes the CPU's `mem_valid`/`mem_ready` accesses into a local register bank, a parametrised DAC code array, a forwarded external-slave window (logic probe or similar) and open-drain bit-bang lines. It also debounces buttons and aggregates interrupts into one masked `irq`. It is the parametrised successor of the fixed top-level glue logic. It adds a single-clock handshake, configurable channel counts, and external-slave timeout.

---
 rtl/io_hub.sv | 185 ++++++++++++++++++
 tb/tb_io_hub.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_hub.sv
// io_hub: tiny16 bus hub with local registers, DAC codes, an external
// slave window with timeout, open-drain lines, debounced buttons and irq.
module io_hub #(
    parameter int OD_LINES        = 2,
    parameter int NBTN            = 2,
    parameter int DAC_CH          = 2,
    parameter int DAC_BITS        = 5,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int EXT_TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [15:0]                address,
    input  logic [15:0]                data_in,
    input  logic                       nwr,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    output logic [15:0]                data_out,
    output logic                       irq,
    output logic                       ext_request,
    input  logic                       ext_ready,
    input  logic [15:0]                ext_data,
    input  logic                       ext_interrupt,
    input  logic [OD_LINES-1:0]        od_in,
    output logic [OD_LINES-1:0]        od_pull_low,
    input  logic [NBTN-1:0]            buttons,
    output logic [DAC_CH*DAC_BITS-1:0] dac_codes
);
    localparam int PW = NBTN + 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [OD_LINES-1:0]   r_od;
    logic [PW-1:0]         r_pend;
    logic [PW-1:0]         r_mask;
    logic                  r_tout;
    logic [15:0]           r_tcnt;
    logic [DAC_BITS-1:0]   r_dac [DAC_CH];
    logic [NBTN-1:0]       r_s1;
    logic [NBTN-1:0]       r_s2;
    logic [NBTN-1:0]       r_deb;
    logic [CW-1:0]         r_cnt [NBTN];

    logic [1:0]            w_region;
    logic [3:0]            w_idx;
    logic                  w_wr;
    logic [NBTN-1:0]       w_deb_rise;
    logic [PW-1:0]         w_pend_set;
    logic [PW-1:0]         w_pend_clr;
    logic [15:0]           w_rdata;
    logic                  w_unused;

    assign w_region    = address[15:14];
    assign w_idx       = address[3:0];
    assign w_wr        = (r_state == S_IDLE) && mem_valid && !nwr;
    assign w_pend_set  = {w_deb_rise, ext_interrupt};
    assign w_pend_clr  = (w_wr && w_region == 2'd0 && w_idx == 4'd1)
                         ? data_in[PW-1:0] : '0;
    assign od_pull_low = ~r_od;
    assign w_unused    = ^{address[13:4], data_in};

    for (genvar k = 0; k < DAC_CH; k++) begin : g_dac
        assign dac_codes[k*DAC_BITS +: DAC_BITS] = r_dac[k];
    end

    always_comb begin
        w_rdata = '0;
        if (w_region == 2'd0) begin
            unique case (w_idx)
                4'd0:    w_rdata = 16'({r_deb, od_in});
                4'd1:    w_rdata = 16'(r_pend);
                4'd2:    w_rdata = 16'(r_mask);
                4'd3:    w_rdata = 16'(r_tout);
                default: w_rdata = '0;
            endcase
        end else if (w_region == 2'd2) begin
            for (int k = 0; k < DAC_CH; k++)
                if (w_idx == 4'(k)) w_rdata = 16'(r_dac[k]);
        end
    end

    // A rise is flagged on the same edge the debounced level flips to 1.
    always_comb begin
        w_deb_rise = '0;
        for (int i = 0; i < NBTN; i++)
            w_deb_rise[i] = r_s2[i] && !r_deb[i]
                            && (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_deb <= '0;
            for (int i = 0; i < NBTN; i++) r_cnt[i] <= '0;
        end else begin
            r_s1 <= buttons;
            r_s2 <= r_s1;
            for (int i = 0; i < NBTN; i++) begin
                if (r_s2[i] != r_deb[i]) begin
                    if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_deb[i] <= r_s2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            mem_ready   <= 1'b0;
            ext_request <= 1'b0;
            data_out    <= '0;
            irq         <= 1'b0;
            r_od        <= '1;
            r_mask      <= '0;
            r_pend      <= '0;
            r_tout      <= 1'b0;
            r_tcnt      <= '0;
            for (int k = 0; k < DAC_CH; k++) r_dac[k] <= '0;
        end else begin
            mem_ready <= 1'b0;
            irq       <= |(r_pend & r_mask);
            r_pend    <= (r_pend & ~w_pend_clr) | w_pend_set;
            unique case (r_state)
                S_IDLE: begin
                    if (mem_valid && w_region == 2'd1) begin
                        ext_request <= 1'b1;
                        r_tcnt      <= '0;
                        r_state     <= S_EXT_WAIT;
                    end else if (mem_valid) begin
                        data_out  <= w_rdata;
                        mem_ready <= 1'b1;
                        r_state   <= S_DONE;
                        if (!nwr && w_region == 2'd0) begin
                            unique case (w_idx)
                                4'd0:    r_od   <= data_in[OD_LINES-1:0];
                                4'd2:    r_mask <= data_in[PW-1:0];
                                4'd3:    r_tout <= 1'b0;
                                default: ;
                            endcase
                        end
                        if (!nwr && w_region == 2'd2) begin
                            for (int k = 0; k < DAC_CH; k++)
                                if (w_idx == 4'(k))
                                    r_dac[k] <= data_in[DAC_BITS-1:0];
                        end
                    end
                end
                S_EXT_WAIT: begin
                    if (ext_ready) begin
                        data_out    <= ext_data;
                        ext_request <= 1'b0;
                        mem_ready   <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_tcnt == 16'(EXT_TIMEOUT)) begin
                        data_out    <= 16'hFFFF;
                        r_tout      <= 1'b1;
                        ext_request <= 1'b0;
                        mem_ready   <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_DONE: begin
                    if (!mem_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_hub.sv
// tb_io_hub: directed scenarios plus randomized bus traffic, all checked
// each cycle against a transaction-level model of the hub.
module tb_io_hub;
    localparam int OD  = 2;
    localparam int NB  = 2;
    localparam int DCH = 2;
    localparam int DB  = 5;
    localparam int DEB = 4;
    localparam int TO  = 4;

    logic              clk = 0;
    logic              nreset = 0;
    logic [15:0]       address = 0;
    logic [15:0]       data_in = 0;
    logic              nwr = 1;
    logic              mem_valid = 0;
    logic              mem_ready;
    logic [15:0]       data_out;
    logic              irq;
    logic              ext_request;
    logic              ext_ready = 0;
    logic [15:0]       ext_data = 0;
    logic              ext_interrupt = 0;
    logic [OD-1:0]     od_in = 0;
    logic [OD-1:0]     od_pull_low;
    logic [NB-1:0]     buttons = 0;
    logic [DCH*DB-1:0] dac_codes;

    io_hub #(
        .OD_LINES(OD), .NBTN(NB), .DAC_CH(DCH), .DAC_BITS(DB),
        .DEBOUNCE_CYCLES(DEB), .EXT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .nreset(nreset), .address(address), .data_in(data_in),
        .nwr(nwr), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .data_out(data_out), .irq(irq), .ext_request(ext_request),
        .ext_ready(ext_ready), .ext_data(ext_data),
        .ext_interrupt(ext_interrupt), .od_in(od_in),
        .od_pull_low(od_pull_low), .buttons(buttons),
        .dac_codes(dac_codes)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    bit   rnd = 0;
    int   ext_delay = 0;
    int   wcnt = 0;
    logic [15:0] ext_val = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // External slave: answers ext_delay cycles after seeing a request.
    always @(negedge clk) begin
        #1;
        if (ext_request === 1'b1 && !ext_ready) begin
            if (wcnt >= ext_delay) begin
                ext_ready = 1;
                ext_data  = rnd ? 16'($urandom) : ext_val;
            end else begin
                wcnt++;
            end
        end else begin
            ext_ready = 0;
            wcnt      = 0;
        end
    end

    // Reference model: register file and bus protocol at transaction level.
    bit            m_live = 0;
    bit            m_wait_ext = 0;
    bit            m_served = 0;
    int            cyc = 0;
    int            m_acc_cyc = 0;
    logic [OD-1:0] m_od;
    logic [NB:0]   m_pend, m_mask, m_set, m_clr;
    logic          m_tout;
    logic [DB-1:0] m_dac [DCH];
    logic [DCH*DB-1:0] m_dacf;
    logic [NB-1:0] m_deb, m_syn;
    int            m_run [NB];
    logic [NB-1:0] m_hist [$];
    logic          m_ready, m_req, m_irq, m_irq_n, m_rd;
    logic [15:0]   m_data, m_rv;
    logic [1:0]    m_reg;
    int            m_idx;
    logic [OD-1:0] e_od;

    always @(posedge clk) begin
        cyc++;
        if (!nreset) begin
            m_live = 1; m_wait_ext = 0; m_served = 0;
            m_od = '1; m_pend = 0; m_mask = 0; m_tout = 0;
            foreach (m_dac[k]) m_dac[k] = 0;
            m_deb = 0;
            foreach (m_run[i]) m_run[i] = 0;
            m_hist.delete();
            m_ready = 0; m_req = 0; m_irq = 0; m_data = 0; m_rd = 0;
        end else begin
            m_irq_n = |(m_pend & m_mask);
            m_clr = 0;
            m_ready = 0;
            m_rd = 0;
            if (m_served) begin
                if (!mem_valid) m_served = 0;
            end else if (m_wait_ext) begin
                if (ext_ready || cyc - m_acc_cyc == TO + 1) begin
                    m_data = ext_ready ? ext_data : 16'hFFFF;
                    if (!ext_ready) m_tout = 1;
                    m_req = 0; m_ready = 1; m_rd = 1;
                    m_wait_ext = 0; m_served = 1;
                end
            end else if (mem_valid) begin
                m_reg = address[15:14];
                m_idx = int'(address[3:0]);
                if (m_reg == 2'd1) begin
                    m_wait_ext = 1; m_req = 1; m_acc_cyc = cyc;
                end else begin
                    m_rv = 0;
                    if (m_reg == 2'd0 && m_idx == 0) m_rv = {m_deb, od_in};
                    if (m_reg == 2'd0 && m_idx == 1) m_rv = 16'(m_pend);
                    if (m_reg == 2'd0 && m_idx == 2) m_rv = 16'(m_mask);
                    if (m_reg == 2'd0 && m_idx == 3) m_rv = 16'(m_tout);
                    if (m_reg == 2'd2 && m_idx < DCH) m_rv = 16'(m_dac[m_idx]);
                    m_data = m_rv; m_rd = nwr; m_ready = 1; m_served = 1;
                    if (!nwr && m_reg == 2'd0) begin
                        if (m_idx == 0) m_od = data_in[OD-1:0];
                        if (m_idx == 1) m_clr = data_in[NB:0];
                        if (m_idx == 2) m_mask = data_in[NB:0];
                        if (m_idx == 3) m_tout = 0;
                    end
                    if (!nwr && m_reg == 2'd2 && m_idx < DCH)
                        m_dac[m_idx] = data_in[DB-1:0];
                end
            end
            // Synced value is the raw sample from two edges back.
            m_syn = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : '0;
            m_hist.push_back(buttons);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
            m_set = 0;
            m_set[0] = ext_interrupt;
            for (int i = 0; i < NB; i++) begin
                if (m_syn[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = m_syn[i];
                        m_run[i] = 0;
                        if (m_syn[i]) m_set[i+1] = 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pend = (m_pend & ~m_clr) | m_set;
            m_irq = m_irq_n;
        end
        for (int k = 0; k < DCH; k++) m_dacf[k*DB +: DB] = m_dac[k];
        e_od = ~m_od;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("mem_ready", mem_ready, m_ready);
            chk("ext_request", ext_request, m_req);
            chk("irq", irq, m_irq);
            chk("od_pull_low", od_pull_low, e_od);
            chk("dac_codes", dac_codes, m_dacf);
            if (m_ready && m_rd) chk("data_out", data_out, m_data);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
            if (rnd) begin
                od_in = OD'($urandom);
                ext_interrupt = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0)
                    buttons = buttons ^ NB'(1 << $urandom_range(0, NB-1));
            end
        end
    endtask

    task automatic xact(input logic [15:0] a, input logic [15:0] d,
                        input bit wr, input int hold, input bit pulse,
                        output logic [15:0] rd, output int lat,
                        output int extra);
        address = a; data_in = d; nwr = !wr; mem_valid = 1;
        if (pulse) ext_interrupt = 1;
        lat = 0; extra = 0; rd = 'x;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (pulse) ext_interrupt = 0;
            lat++;
            if (mem_ready === 1'b1) break;
        end
        chk("ready_seen", {31'b0, mem_ready === 1'b1}, 1);
        rd = data_out;
        repeat (hold) begin
            tick(1);
            if (mem_ready === 1'b1) extra++;
        end
        mem_valid = 0; nwr = 1;
        tick(1);
    endtask

    logic [15:0] rd;
    int lat, ex;

    initial begin
        nreset = 0;
        tick(3);
        chk("rst_ready", mem_ready, 0);
        chk("rst_req", ext_request, 0);
        chk("rst_irq", irq, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_od", od_pull_low, 0);
        chk("rst_dac", dac_codes, 0);
        nreset = 1;
        tick(1);

        xact(16'h8001, 16'h0013, 1, 0, 0, rd, lat, ex);
        chk("dac_lat", lat, 1);
        chk("dac_ch1", dac_codes[2*DB-1:DB], 5'h13);
        xact(16'h8001, 0, 0, 0, 0, rd, lat, ex);
        chk("dac_rd", rd, 16'h0013);
        xact(16'h8005, 0, 0, 0, 0, rd, lat, ex);
        chk("dac_oor", rd, 0);

        xact(16'h0000, 16'h0000, 1, 0, 0, rd, lat, ex);
        chk("od_low", od_pull_low, 2'b11);
        od_in = 2'b10;
        xact(16'h0000, 0, 0, 5, 0, rd, lat, ex);
        chk("io_rd", rd, 16'h0002);
        chk("one_access", ex, 0);

        ext_delay = 3; ext_val = 16'hBEEF;
        xact(16'h4000, 0, 0, 0, 0, rd, lat, ex);
        chk("ext_rd", rd, 16'hBEEF);
        chk("ext_lat", lat, 5);
        chk("ext_req_off", ext_request, 0);
        xact(16'h0003, 0, 0, 0, 0, rd, lat, ex);
        chk("no_tout", rd, 0);

        ext_delay = 1000;
        xact(16'h4000, 0, 0, 0, 0, rd, lat, ex);
        chk("tout_rd", rd, 16'hFFFF);
        chk("tout_lat", lat, TO + 2);
        xact(16'h0003, 0, 0, 0, 0, rd, lat, ex);
        chk("tout_flag", rd, 1);
        xact(16'h0003, 16'h1234, 1, 0, 0, rd, lat, ex);
        xact(16'h0003, 0, 0, 0, 0, rd, lat, ex);
        chk("tout_clr", rd, 0);

        xact(16'h0001, 16'h0007, 1, 0, 0, rd, lat, ex);
        buttons = 2'b01; tick(2);
        buttons = 2'b00; tick(10);
        xact(16'h0001, 0, 0, 0, 0, rd, lat, ex);
        chk("glitch", rd, 0);
        buttons = 2'b01; tick(8);
        xact(16'h0001, 0, 0, 0, 0, rd, lat, ex);
        chk("btn_pend", rd, 16'h0002);
        xact(16'h0002, 16'h0002, 1, 0, 0, rd, lat, ex);
        tick(2);
        chk("irq_on", irq, 1);
        xact(16'h0001, 16'h0002, 1, 0, 0, rd, lat, ex);
        tick(2);
        chk("irq_off", irq, 0);
        xact(16'h0001, 16'h0001, 1, 0, 1, rd, lat, ex);
        xact(16'h0001, 0, 0, 0, 0, rd, lat, ex);
        chk("set_wins", rd, 16'h0001);

        ext_delay = 1000;
        address = 16'h4000; nwr = 1; mem_valid = 1;
        tick(3);
        chk("mid_req", ext_request, 1);
        nreset = 0; mem_valid = 0; buttons = 0;
        tick(1);
        chk("mid_req_off", ext_request, 0);
        chk("mid_ready", mem_ready, 0);
        chk("mid_dout", data_out, 0);
        chk("mid_od", od_pull_low, 0);
        chk("mid_dac", dac_codes, 0);
        chk("mid_irq", irq, 0);
        nreset = 1;
        tick(2);

        rnd = 1;
        repeat (300) begin
            logic [15:0] a;
            a = {2'($urandom_range(0, 3)), 10'b0, 4'($urandom_range(0, 5))};
            ext_delay = $urandom_range(0, 6);
            xact(a, 16'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), 0, rd, lat, ex);
            tick($urandom_range(0, 2));
        end
        rnd = 0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
